// File: rtl/twiddle_rot_108.sv
// twiddle_rot_108: inter-stage twiddle rotator for the 108-point mixed-radix DFT.
// Walks the ROWS x COLS frame (col is the inner index) and drives the twiddle ROM
// address k = row*col mod 108. When inv is set, the address is (108 - k) mod 108.
// Each sample is multiplied by the Q8 twiddle through a three-stage pipeline.
// Build option TWROT_SAT_EN makes the final stage saturate instead of wrap.
module twiddle_rot_108 #(
  parameter int DW   = 18,
  parameter int ROWS = 4,
  parameter int COLS = 27
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inv,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic [10:0]   tw_addr,
  input  logic [17:0]   tw_re,
  input  logic [17:0]   tw_im,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eof,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          frm_err
);

  localparam int N  = 108;
  localparam int MW = DW + 18;   // product width
  localparam int PW = DW + 19;   // sum-of-products width
  localparam int SW = PW - 8;    // width after dropping the 8 fraction bits

  localparam logic [6:0]    ROW_LAST = 7'(ROWS - 1);
  localparam logic [6:0]    COL_LAST = 7'(COLS - 1);
  localparam logic [6:0]    N7       = 7'(N);
  localparam logic [7:0]    N8       = 8'(N);
  localparam logic [PW-1:0] RND      = PW'(128);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

`ifdef TWROT_SAT_EN
  // Clamp a post-shift value into the signed DW-bit output range.
  function automatic logic [DW-1:0] sat_fn(input logic [SW-1:0] v);
    logic [DW-1:0] r;
    if (v[SW-1:DW-1] == {(SW-DW+1){v[SW-1]}}) begin
      r = v[DW-1:0];
    end else if (v[SW-1]) begin
      r = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r = {1'b0, {(DW-1){1'b1}}};
    end
    return r;
  endfunction
`endif

  // Frame position state. It describes the beat expected next.
  state_t      state_q, state_d;
  logic [6:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [6:0]  acc_q, acc_d;
  logic        inv_q, inv_d;
  logic        frm_err_q, frm_err_d;

  // Pipeline registers
  logic          s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
  logic [DW-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [17:0]   s1_c_q, s1_c_d, s1_d_q, s1_d_d;
  logic          s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d, s2_eof_q, s2_eof_d;
  logic [PW-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;
  logic          out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  logic [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;

  // Current-beat decode signals
  logic        restart_s, beat_s, err_s, last_s, cur_inv_s;
  logic [6:0]  cur_row_s, cur_col_s, cur_acc_s, acc_wrap_s, addr_s;
  logic [7:0]  acc_sum_s;

  // Datapath intermediates
  logic [MW-1:0] a_x_s, b_x_s, c_x_s, d_x_s;
  logic [MW-1:0] p_ac_s, p_bd_s, p_ad_s, p_bc_s;
  logic [PW-1:0] rnd_re_s, rnd_im_s;
  logic [SW-1:0] sh_re_s, sh_im_s;
  logic          unused_bits_s;

  // Decode the current beat. A sof beat always counts as index 0 with the live inv.
  always_comb begin
    restart_s  = in_valid & in_sof;
    cur_row_s  = restart_s ? 7'd0 : row_q;
    cur_col_s  = restart_s ? 7'd0 : col_q;
    cur_acc_s  = restart_s ? 7'd0 : acc_q;
    cur_inv_s  = restart_s ? inv : inv_q;
    last_s     = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    acc_sum_s  = {1'b0, cur_acc_s} + {1'b0, cur_row_s};
    acc_wrap_s = acc_sum_s[6:0];
    addr_s     = cur_acc_s;
    beat_s     = 1'b0;
    err_s      = 1'b0;
    // The wrap is kept as a guard for other ROWS/COLS factorisations.
    if (acc_sum_s >= N8) begin
      acc_wrap_s = 7'(acc_sum_s - N8);
    end else begin
      acc_wrap_s = acc_sum_s[6:0];
    end
    if (cur_inv_s && (cur_acc_s != 7'd0)) begin
      addr_s = N7 - cur_acc_s;
    end else begin
      addr_s = cur_acc_s;
    end
    case (state_q)
      IDLE: begin
        beat_s = restart_s;
        err_s  = in_valid & ~in_sof;
      end
      RUN: begin
        beat_s = in_valid;
        err_s  = restart_s;
      end
      default: begin
        beat_s = 1'b0;
        err_s  = 1'b0;
      end
    endcase
  end

  assign tw_addr = {4'd0, addr_s};

  // Next frame position. Counters advance only on accepted beats.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    acc_d     = acc_q;
    inv_d     = inv_q;
    frm_err_d = frm_err_q | err_s;
    if (beat_s) begin
      inv_d = cur_inv_s;
      if (last_s) begin
        state_d = IDLE;
        row_d   = 7'd0;
        col_d   = 7'd0;
        acc_d   = 7'd0;
      end else if (cur_col_s == COL_LAST) begin
        state_d = RUN;
        row_d   = cur_row_s + 7'd1;
        col_d   = 7'd0;
        acc_d   = 7'd0;
      end else begin
        state_d = RUN;
        row_d   = cur_row_s;
        col_d   = cur_col_s + 7'd1;
        acc_d   = acc_wrap_s;
      end
    end else begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      acc_d   = acc_q;
      inv_d   = inv_q;
    end
  end

  // Pipeline stages: S1 capture, S2 complex multiply, S3 round and resize.
  always_comb begin
    s1_valid_d = beat_s;
    s1_sof_d   = beat_s & restart_s;
    s1_eof_d   = beat_s & last_s;
    s1_a_d     = in_re;
    s1_b_d     = in_im;
    s1_c_d     = tw_re;
    s1_d_d     = tw_im;

    a_x_s  = {{18{s1_a_q[DW-1]}}, s1_a_q};
    b_x_s  = {{18{s1_b_q[DW-1]}}, s1_b_q};
    c_x_s  = {{DW{s1_c_q[17]}}, s1_c_q};
    d_x_s  = {{DW{s1_d_q[17]}}, s1_d_q};
    p_ac_s = a_x_s * c_x_s;
    p_bd_s = b_x_s * d_x_s;
    p_ad_s = a_x_s * d_x_s;
    p_bc_s = b_x_s * c_x_s;
    s2_valid_d = s1_valid_q;
    s2_sof_d   = s1_sof_q;
    s2_eof_d   = s1_eof_q;
    s2_re_d    = {p_ac_s[MW-1], p_ac_s} - {p_bd_s[MW-1], p_bd_s};
    s2_im_d    = {p_ad_s[MW-1], p_ad_s} + {p_bc_s[MW-1], p_bc_s};

    rnd_re_s    = s2_re_q + RND;
    rnd_im_s    = s2_im_q + RND;
    sh_re_s     = rnd_re_s[PW-1:8];
    sh_im_s     = rnd_im_s[PW-1:8];
    out_valid_d = s2_valid_q;
    out_sof_d   = s2_sof_q;
    out_eof_d   = s2_eof_q;
`ifdef TWROT_SAT_EN
    out_re_d      = sat_fn(sh_re_s);
    out_im_d      = sat_fn(sh_im_s);
    unused_bits_s = ^{rnd_re_s[7:0], rnd_im_s[7:0]};
`else
    out_re_d      = sh_re_s[DW-1:0];
    out_im_d      = sh_im_s[DW-1:0];
    unused_bits_s = ^{rnd_re_s[7:0], rnd_im_s[7:0], sh_re_s[SW-1:DW], sh_im_s[SW-1:DW]};
`endif
  end

  // State and pipeline registers. Reset flushes everything, so no partial frame escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= 7'd0;
      col_q       <= 7'd0;
      acc_q       <= 7'd0;
      inv_q       <= 1'b0;
      frm_err_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= 18'd0;
      s1_d_q      <= 18'd0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_eof_q    <= 1'b0;
      s2_re_q     <= '0;
      s2_im_q     <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      inv_q       <= inv_d;
      frm_err_q   <= frm_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_eof_q    <= s1_eof_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s1_d_q      <= s1_d_d;
      s2_valid_q  <= s2_valid_d;
      s2_sof_q    <= s2_sof_d;
      s2_eof_q    <= s2_eof_d;
      s2_re_q     <= s2_re_d;
      s2_im_q     <= s2_im_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_twiddle_rot_108.sv
// Directed bench for twiddle_rot_108 with an attached Q8 twiddle ROM model.
// Checks the address sequence, the rotated outputs and their latency, the framing
// flags, error handling, and reset behaviour.
module tb_twiddle_rot_108;

  logic               clk;
  logic               rst_n;
  logic               inv;
  logic               in_valid;
  logic               in_sof;
  logic signed [17:0] in_re, in_im;
  logic [10:0]        tw_addr;
  logic signed [17:0] tw_re, tw_im;
  logic               out_valid, out_sof, out_eof;
  logic signed [17:0] out_re, out_im;
  logic               frm_err;

  typedef struct {
    int re;
    int im;
    bit sof;
    bit eof;
    int cyc;
    int idx;
    int mode;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   eof_cnt = 0;

  twiddle_rot_108 #(.DW(18), .ROWS(4), .COLS(27)) dut (
    .clk(clk), .rst_n(rst_n), .inv(inv), .in_valid(in_valid), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_re(out_re), .out_im(out_im), .frm_err(frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Twiddle ROM contents: 256*exp(+j*2*pi*k/108), rounded to nearest.
  function automatic int rom_cos(input int k);
    return $rtoi($floor(256.0 * $cos(2.0 * 3.14159265358979 * k / 108.0) + 0.5));
  endfunction
  function automatic int rom_sin(input int k);
    return $rtoi($floor(256.0 * $sin(2.0 * 3.14159265358979 * k / 108.0) + 0.5));
  endfunction

  always_comb begin
    tw_re = 18'sd0;
    tw_im = 18'sd0;
    if (tw_addr < 11'd108) begin
      tw_re = 18'(rom_cos(int'(tw_addr)));
      tw_im = 18'(rom_sin(int'(tw_addr)));
    end
  end

  task automatic check(input string tag, input longint obs, input longint expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Round half up, drop 8 fraction bits, then fit to 18 bits.
`ifdef TWROT_SAT_EN
  function automatic int fit(input longint p);
    longint q;
    q = (p + 128) >>> 8;
    if (q > 131071) return 131071;
    if (q < -131072) return -131072;
    return int'(q);
  endfunction
`else
  function automatic int fit(input longint p);
    longint q;
    logic signed [17:0] t;
    q = (p + 128) >>> 8;
    t = q[17:0];
    return int'(t);
  endfunction
`endif

  // Output monitor: every valid output must match the oldest expected sample.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_re", out_re, e.re);
        check("out_im", out_im, e.im);
        check("out_sof", out_sof, e.sof);
        check("out_eof", out_eof, e.eof);
        check("latency", cyc - e.cyc, 3);
        if (e.mode == 0 && e.idx < 27) begin
          check("row0_re", out_re, 1000);
          check("row0_im", out_im, -500);
        end
        if (e.mode == 1 && e.idx == 90) begin
          check("addr27_re", out_re, 0);
          check("addr27_im", out_im, 256);
        end
        if (e.mode == 1 && e.idx == 99) begin
`ifdef TWROT_SAT_EN
          check("sat_re", out_re, 131071);
`else
          check("wrap_re", out_re, -131072);
`endif
        end
        if (out_eof) eof_cnt <= eof_cnt + 1;
      end
    end
  end

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drive a frame. Mode 0: (1000,-500). Mode 1: (256,0) with (-131072,0) at index 99.
  // Mode 2: (256,0). restart_at >= 0 injects a sof at that beat; stop_after > 0 truncates.
  task automatic run_frame(input bit inv_i, input bit gaps, input int mode,
                           input int restart_at, input int stop_after);
    int   idx, total, r, c, k, re, im;
    exp_t e;
    idx   = 0;
    total = (restart_at > 0) ? restart_at + 108 : 108;
    if (stop_after > 0) total = stop_after;
    for (int i = 0; i < total; i++) begin
      if (gaps && i > 0) begin
        while ($urandom_range(1, 0) == 0) idle_cycle();
      end
      if (i == restart_at) idx = 0;
      r = idx / 27;
      c = idx % 27;
      k = (r * c) % 108;
      if (inv_i && k != 0) k = 108 - k;
      case (mode)
        0:       begin re = 1000; im = -500; end
        1:       begin re = (idx == 99) ? -131072 : 256; im = 0; end
        default: begin re = 256; im = 0; end
      endcase
      in_valid = 1'b1;
      in_sof   = (i == 0) || (i == restart_at);
      inv      = inv_i;
      in_re    = 18'(re);
      in_im    = 18'(im);
      #1;
      check("tw_addr", tw_addr, k);
      if (!inv_i && r == 1) check("addr_row1", tw_addr, c);
      if (!inv_i && r == 3) check("addr_row3", tw_addr, 3 * c);
      if (inv_i && r == 1 && c == 1) check("inv_r1c1", tw_addr, 107);
      if (inv_i && r == 3 && c == 26) check("inv_r3c26", tw_addr, 30);
      if (i == restart_at) check("frm_err_pre", frm_err, 0);
      e.re   = fit(longint'(re) * rom_cos(k) - longint'(im) * rom_sin(k));
      e.im   = fit(longint'(re) * rom_sin(k) + longint'(im) * rom_cos(k));
      e.sof  = in_sof;
      e.eof  = (idx == 107);
      e.cyc  = cyc;
      e.idx  = idx;
      e.mode = mode;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (i == restart_at) check("frm_err_post", frm_err, 1);
      idx++;
    end
  endtask

  initial begin
    int base;
    rst_n    = 1'b0;
    inv      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_re    = 18'sd0;
    in_im    = 18'sd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eof", out_eof, 0);
    check("rst_frm_err", frm_err, 0);
    check("rst_tw_addr", tw_addr, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Gap-free frame, then a gapped frame starting on the very next beat.
    base = eof_cnt;
    run_frame(1'b0, 1'b0, 0, -1, 0);
    run_frame(1'b0, 1'b1, 0, -1, 0);
    repeat (5) idle_cycle();
    check("eof_count_f12", eof_cnt - base, 2);

    // Inverse frame, then a forward frame covering addr 27 and the overflow case.
    base = eof_cnt;
    run_frame(1'b1, 1'b0, 2, -1, 0);
    run_frame(1'b0, 1'b0, 1, -1, 0);
    repeat (5) idle_cycle();
    check("eof_count_f34", eof_cnt - base, 2);
    check("frm_err_clean", frm_err, 0);

    // sof injected at beat 40 of a running frame.
    base = eof_cnt;
    run_frame(1'b0, 1'b0, 0, 40, 0);
    repeat (5) idle_cycle();
    check("eof_count_restart", eof_cnt - base, 1);
    check("frm_err_sticky", frm_err, 1);

    // Reset asserted mid-frame, while the pipeline holds valid data.
    run_frame(1'b0, 1'b0, 0, -1, 10);
    #1;
    rst_n = 1'b0;
    #1;
    check("amid_out_valid", out_valid, 0);
    check("amid_out_re", out_re, 0);
    check("amid_out_im", out_im, 0);
    check("amid_out_sof", out_sof, 0);
    check("amid_frm_err", frm_err, 0);
    check("amid_tw_addr", tw_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) idle_cycle();

    // A valid beat without sof in IDLE is dropped and flagged.
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_re    = 18'sd77;
    in_im    = 18'sd77;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("drop_frm_err", frm_err, 1);
    repeat (5) idle_cycle();

    // The dropped beat must not disturb the next frame.
    base = eof_cnt;
    run_frame(1'b0, 1'b1, 2, -1, 0);
    repeat (5) idle_cycle();
    check("eof_count_last", eof_cnt - base, 1);
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
